// File: rtl/alt_integrator.sv
// Altitude integrator for a single vertical flight: integrates burn velocity samples,
// then coasts under constant gravity until apex, capturing the apex altitude.
module alt_integrator #(
  parameter int VW     = 48,
  parameter int G_STEP = 9799
) (
  input  logic          clk,
  input  logic          resetb,
  input  logic          start,
  input  logic          tick,
  input  logic          vel_valid,
  input  logic [VW-1:0] vel_in,
  output logic          vel_ready,
  input  logic          burn_done,
  output logic [63:0]   altitude,
  output logic [VW:0]   vel_out,
  output logic [1:0]    state,
  output logic          apex_valid,
  output logic [63:0]   apex_alt,
  output logic [15:0]   miss_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURN  = 2'd1,
    COAST = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [VW-1:0] GSTEP = VW'(G_STEP);

  function automatic logic [63:0] sat_add64(input logic [63:0] a, input logic [63:0] b);
    logic [64:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[64] ? {64{1'b1}} : s[63:0];
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] a);
    return (a == 16'hFFFF) ? a : a + 16'd1;
  endfunction

  state_t                state_q, state_d;
  logic signed [VW:0]    vel_q;
  logic signed [VW+1:0]  vel_next;
  logic [63:0]           vel_pos, alt_add, alt_next;
  logic [1:0]            rst_sync;
  logic                  rstn, launch, burn_tick, coast_tick, apex_hit;

  // Reset asserts immediately but releases two clock edges later.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) rst_sync <= 2'b00;
    else         rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rstn = rst_sync[1];

  assign launch     = start && (state_q == IDLE || state_q == DONE);
  assign burn_tick  = tick && (state_q == BURN);
  assign coast_tick = tick && (state_q == COAST);

  // Negative velocity contributes nothing to altitude.
  assign vel_pos  = vel_q[VW] ? 64'd0 : 64'(vel_q[VW-1:0]);
  assign vel_next = $signed({vel_q[VW], vel_q}) - $signed({2'b00, GSTEP});
  assign apex_hit = vel_next[VW+1] || (vel_next == '0);

  assign alt_add  = (burn_tick && vel_valid) ? 64'(vel_in) : vel_pos;
  assign alt_next = sat_add64(altitude, alt_add);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (start)                 state_d = BURN;
      BURN:       if (burn_done)             state_d = COAST;
      COAST:      if (coast_tick && apex_hit) state_d = DONE;
      default:                               state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      altitude   <= '0;
      vel_q      <= '0;
      apex_alt   <= '0;
      apex_valid <= 1'b0;
      miss_cnt   <= '0;
    end else begin
      apex_valid <= 1'b0;
      if (launch) begin
        altitude <= '0;
        vel_q    <= '0;
        apex_alt <= '0;
        miss_cnt <= '0;
      end else if (burn_tick) begin
        altitude <= alt_next;
        if (vel_valid) vel_q    <= $signed({1'b0, vel_in});
        else           miss_cnt <= sat_inc16(miss_cnt);
      end else if (coast_tick) begin
        altitude <= alt_next;
        if (apex_hit) begin
          vel_q      <= '0;
          apex_alt   <= alt_next;
          apex_valid <= 1'b1;
        end else begin
          vel_q <= $signed(vel_next[VW:0]);
        end
      end
    end
  end

  assign vel_out   = vel_q;
  assign state     = state_q;
  assign vel_ready = (state_q == BURN);

endmodule

// File: tb/tb_alt_integrator.sv
// Scoreboard bench for alt_integrator: a flight-level reference model predicts every
// cycle's outputs, a monitor compares them after each rising edge.
module tb_alt_integrator;
  localparam int VW = 48;
  localparam int G  = 9799;

  logic          clk = 1'b0;
  logic          resetb, start, tick, vel_valid, burn_done;
  logic [VW-1:0] vel_in;
  logic          vel_ready, apex_valid;
  logic [63:0]   altitude, apex_alt;
  logic [VW:0]   vel_out;
  logic [1:0]    state;
  logic [15:0]   miss_cnt;

  alt_integrator #(.VW(VW), .G_STEP(G)) dut (
    .clk(clk), .resetb(resetb), .start(start), .tick(tick), .vel_valid(vel_valid),
    .vel_in(vel_in), .vel_ready(vel_ready), .burn_done(burn_done), .altitude(altitude),
    .vel_out(vel_out), .state(state), .apex_valid(apex_valid), .apex_alt(apex_alt),
    .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] alt;
    logic [63:0] vel;
    logic [1:0]  st;
    logic        rdy;
    logic        av;
    logic [63:0] aa;
    logic [15:0] miss;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference flight model
  int          m_state, m_hold, m_miss;
  longint      m_vel;
  logic [63:0] m_alt, m_apex_alt;
  logic        m_apex_v;

  function automatic logic [63:0] add_sat(input logic [63:0] a, input logic [63:0] b);
    logic [64:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s > 65'h0_FFFF_FFFF_FFFF_FFFF) return 64'hFFFF_FFFF_FFFF_FFFF;
    return s[63:0];
  endfunction

  task automatic model_clear();
    m_alt = 0; m_vel = 0; m_apex_alt = 0; m_miss = 0;
  endtask

  task automatic model_step(input logic st, input logic tk, input logic vv,
                            input logic [VW-1:0] vin, input logic bd);
    longint nv;
    m_apex_v = 1'b0;
    if (!resetb) begin
      m_state = 0; m_hold = 2; model_clear();
    end else if (m_hold > 0) begin
      m_hold--; m_state = 0; model_clear();
    end else begin
      case (m_state)
        0, 3: if (st) begin model_clear(); m_state = 1; end
        1: begin
          if (tk) begin
            if (vv) begin
              m_alt = add_sat(m_alt, 64'(vin));
              m_vel = longint'(vin);
            end else begin
              m_alt = add_sat(m_alt, 64'(m_vel));
              if (m_miss < 65535) m_miss++;
            end
          end
          if (bd) m_state = 2;
        end
        default: begin
          if (tk) begin
            m_alt = add_sat(m_alt, (m_vel > 0) ? 64'(m_vel) : 64'd0);
            nv = m_vel - G;
            if (nv <= 0) begin
              m_vel = 0; m_apex_alt = m_alt; m_apex_v = 1'b1; m_state = 3;
            end else begin
              m_vel = nv;
            end
          end
        end
      endcase
    end
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Called at a falling edge: drive inputs, predict the next edge, wait one cycle.
  task automatic cyc(input logic st, input logic tk, input logic vv,
                     input logic [VW-1:0] vin, input logic bd);
    exp_t e;
    start = st; tick = tk; vel_valid = vv; vel_in = vin; burn_done = bd;
    model_step(st, tk, vv, vin, bd);
    e.alt = m_alt; e.vel = 64'(m_vel[VW:0]); e.st = 2'(m_state);
    e.rdy = (m_state == 1); e.av = m_apex_v; e.aa = m_apex_alt; e.miss = 16'(m_miss);
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    resetb = 1'b0;
    #1;
    chk("async_rst_alt", altitude, 64'd0);
    chk("async_rst_state", 64'(state), 64'd0);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, '0, 1'b0);
    resetb = 1'b1;
  endtask

  task automatic run_req035();
    cyc(1'b1, 1'b0, 1'b0, '0, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 48'd1000, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 48'd2000, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 48'd3000, 1'b0);
    chk("r35_alt", altitude, 64'd6000);
    chk("r35_vel", 64'(vel_out), 64'd3000);
    chk("r35_miss", 64'(miss_cnt), 64'd0);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("altitude", altitude, e.alt);
        chk("vel_out", 64'(vel_out), e.vel);
        chk("state", 64'(state), 64'(e.st));
        chk("vel_ready", 64'(vel_ready), 64'(e.rdy));
        chk("apex_valid", 64'(apex_valid), 64'(e.av));
        chk("apex_alt", apex_alt, e.aa);
        chk("miss_cnt", 64'(miss_cnt), 64'(e.miss));
      end
    end
  end

  initial begin
    resetb = 1'b0; start = 1'b0; tick = 1'b0; vel_valid = 1'b0; vel_in = '0; burn_done = 1'b0;
    m_state = 0; m_hold = 2; m_apex_v = 1'b0; model_clear();
    @(negedge clk);
    do_reset(2);
    // Idle, including strobes that must be ignored
    for (int i = 0; i < 10; i++) cyc(1'b0, i[0], 1'b1, 48'd777, i[1]);
    chk("r34_state", 64'(state), 64'd0);
    chk("r34_ready", 64'(vel_ready), 64'd0);

    run_req035();
    cyc(1'b0, 1'b0, 1'b1, 48'd5555, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, '0, 1'b0);
    chk("hold_alt", altitude, 64'd6000);
    cyc(1'b0, 1'b1, 1'b0, '0, 1'b0);
    chk("r36_alt", altitude, 64'd9000);
    chk("r36_miss", 64'(miss_cnt), 64'd1);
    cyc(1'b0, 1'b1, 1'b1, 48'd500, 1'b1);
    chk("r37_alt", altitude, 64'd9500);
    chk("r37_vel", 64'(vel_out), 64'd500);
    chk("r37_state", 64'(state), 64'd2);
    cyc(1'b0, 1'b1, 1'b0, '0, 1'b0);
    chk("neg_apex_alt", apex_alt, 64'd10000);
    chk("neg_state", 64'(state), 64'd3);

    cyc(1'b1, 1'b0, 1'b0, '0, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 48'd29397, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, '0, 1'b1);
    cyc(1'b0, 1'b1, 1'b0, '0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, '0, 1'b0);
    chk("r38_mid_alt", altitude, 64'd78392);
    cyc(1'b0, 1'b1, 1'b0, '0, 1'b0);
    chk("r38_apex_valid", 64'(apex_valid), 64'd1);
    chk("r38_apex_alt", apex_alt, 64'd88191);
    chk("r38_vel", 64'(vel_out), 64'd0);
    chk("r38_state", 64'(state), 64'd3);

    cyc(1'b1, 1'b0, 1'b0, '0, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 48'd29397, 1'b1);
    cyc(1'b0, 1'b1, 1'b0, '0, 1'b0);
    do_reset(2);
    cyc(1'b1, 1'b0, 1'b0, '0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, '0, 1'b0);
    chk("r39_state", 64'(state), 64'd0);
    run_req035();

    // Saturation of altitude and miss counter
    cyc(1'b0, 1'b1, 1'b1, {VW{1'b1}}, 1'b0);
    for (int i = 0; i < 65600; i++) cyc(1'b0, 1'b1, 1'b0, '0, 1'b0);
    chk("sat_alt", altitude, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("sat_miss", 64'(miss_cnt), 64'hFFFF);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) do_reset(2);
      else cyc(($urandom_range(0, 19) == 0), ($urandom_range(0, 1) == 1),
               ($urandom_range(0, 3) != 0), VW'($urandom_range(0, 60000)),
               ($urandom_range(0, 14) == 0));
    end
    start = 1'b0; tick = 1'b0; burn_done = 1'b0;
    @(negedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alt_integrator.md
ALT_INTEGRATOR -- requirements
Module: alt_integrator

Interface
REQ-001 Parameter VW, default 48: velocity magnitude width in bits, unsigned, units um/s.
REQ-002 Parameter G_STEP, default 9799: velocity decrement per tick in um/s (9.799 m/s^2 x 1 ms).
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 resetb  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  one-cycle pulse; begins a new flight from IDLE or DONE.
REQ-006 tick  input  1  one-cycle 1 ms integration strobe.
REQ-007 vel_valid  input  1  velocity sample from the upstream Tsiolkovsky velocity stage is valid.
REQ-008 vel_in  input  VW  instantaneous burn velocity, unsigned, um/s.
REQ-009 vel_ready  output  1  high only in BURN; a sample transfers when vel_valid & vel_ready & tick.
REQ-010 burn_done  input  1  one-cycle pulse; propellant exhausted.
REQ-011 altitude  output  64  integrated altitude, unsigned, nm (um/s x 1 ms).
REQ-012 vel_out  output  VW+1  current velocity, two's-complement signed, um/s.
REQ-013 state  output  2  IDLE=0, BURN=1, COAST=2, DONE=3.
REQ-014 apex_valid  output  1  one-cycle pulse at apex detection.
REQ-015 apex_alt  output  64  altitude captured at apex, nm.
REQ-016 miss_cnt  output  16  BURN ticks with no valid sample, saturating at 16'hFFFF.

Function
REQ-017 IDLE: altitude, vel_out, and miss_cnt hold; tick, vel_valid, and burn_done are ignored.
REQ-018 A start pulse in IDLE or DONE clears altitude, vel_out, apex_alt, and miss_cnt to 0 and enters BURN on the next cycle.
REQ-019 A start pulse in BURN or COAST is ignored.
REQ-020 BURN, tick with vel_valid: vel_out <= zero-extended vel_in; altitude <= altitude + vel_in, using the new sample in the same cycle.
REQ-021 BURN, tick without vel_valid: altitude <= altitude + vel_out, holding the last value; miss_cnt increments.
REQ-022 BURN, vel_valid without tick: no transfer; vel_ready stays high and the sample is not consumed.
REQ-023 BURN, burn_done: enter COAST next cycle; if tick and a transfer occur in the same cycle, the transfer completes first.
REQ-024 COAST, tick: altitude <= altitude + max(vel_out, 0); vel_next = vel_out - G_STEP.
REQ-025 COAST, if vel_next <= 0: vel_out <= 0; apex_alt <= the updated altitude; apex_valid pulses the same cycle the registers update; enter DONE.
REQ-026 COAST, if vel_next > 0: vel_out <= vel_next; remain in COAST.
REQ-027 DONE: all outputs hold; apex_valid is 0; only start is accepted.
REQ-028 Altitude addition saturates at 64'hFFFF_FFFF_FFFF_FFFF and never wraps.
REQ-029 Output latency: registered outputs reflect a tick one cycle after the tick edge; no combinational path from inputs to altitude or vel_out.
REQ-030 burn_done outside BURN is ignored.

Reset
REQ-031 On resetb low, asynchronously: state=IDLE; altitude, vel_out, apex_alt, and miss_cnt = 0; apex_valid=0; vel_ready=0.
REQ-032 Reset asserted mid-flight (BURN or COAST) aborts the flight; apex_valid does not pulse for the aborted flight.
REQ-033 Release of resetb is synchronized to clk; the first start pulse is honored two or more cycles after release.

Verification
REQ-034 Reset then idle 10 cycles -> state=0, altitude=0, vel_out=0, vel_ready=0, apex_valid never high.
REQ-035 start, then 3 ticks with vel_in=1000, 2000, 3000 (valid each) -> altitude=6000, vel_out=3000, miss_cnt=0.
REQ-036 BURN with vel_out=3000, one tick with vel_valid=0 -> altitude increases by 3000, miss_cnt=1.
REQ-037 burn_done coincident with tick and vel_in=500 valid -> altitude +500, vel_out=500, state=COAST next cycle.
REQ-038 COAST from vel_out=29397, G_STEP=9799 -> ticks add 29397, 19598, 9799 to altitude; apex_valid pulses on the 3rd tick; apex_alt=altitude; vel_out=0; state=DONE.
REQ-039 resetb pulsed low during COAST after 1 tick -> all outputs 0, state=IDLE, no apex_valid; a subsequent start reruns the REQ-035 scenario correctly.
